// File: rtl/bram_fifo_ex.sv
// rtl/bram_fifo_ex.sv - parametrised block-RAM FIFO with standard or first-word-fall-through read
module bram_fifo_ex #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 1024,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH:0]   data_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_acc;
    logic                  rd_acc;

    // flush outranks any transfer requested in the same cycle
    assign wr_acc       = wr_en & ~full & ~flush;
    assign rd_acc       = rd_en & ~empty & ~flush;
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);
    assign data_count   = count;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            overflow  <= (wr_en & full) | (overflow & ~err_clr);
            underflow <= (rd_en & empty) | (underflow & ~err_clr);
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            assign empty = (count == '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_ptr   <= '0;
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else if (flush) begin
                    rd_ptr   <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                        rd_ptr  <= rd_ptr + ONE;
                    end
                end
            end
        end else begin : g_fwft
            // two-stage prefetch: RAM read register, then the visible output register
            logic [DATA_WIDTH-1:0] stage_data;
            logic                  stage_valid;
            logic                  out_valid;
            logic                  stage_take;
            logic                  stage_load;

            assign empty      = ~out_valid;
            assign rd_valid   = out_valid;
            assign stage_take = stage_valid & (~out_valid | rd_acc);
            assign stage_load = (wr_ptr != rd_ptr) & (~stage_valid | stage_take);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_ptr      <= '0;
                    stage_data  <= '0;
                    stage_valid <= 1'b0;
                    out_valid   <= 1'b0;
                    rd_data     <= '0;
                end else if (flush) begin
                    rd_ptr      <= '0;
                    stage_valid <= 1'b0;
                    out_valid   <= 1'b0;
                end else begin
                    if (stage_load) begin
                        stage_data  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                        stage_valid <= 1'b1;
                        rd_ptr      <= rd_ptr + ONE;
                    end else if (stage_take) begin
                        stage_valid <= 1'b0;
                    end
                    if (stage_take) begin
                        rd_data   <= stage_data;
                        out_valid <= 1'b1;
                    end else if (rd_acc) begin
                        out_valid <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_bram_fifo_ex.sv
// tb/tb_bram_fifo_ex.sv - scoreboard bench running standard and FWFT instances side by side
module tb_bram_fifo_ex;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [AW:0]   af_thresh = 5'd12;
    logic [AW:0]   ae_thresh = 5'd3;

    logic          s_full, s_afull, s_rd_valid, s_empty, s_aempty, s_ovf, s_unf;
    logic [DW-1:0] s_rd_data;
    logic [AW:0]   s_count;
    logic          f_full, f_afull, f_rd_valid, f_empty, f_aempty, f_ovf, f_unf;
    logic [DW-1:0] f_rd_data;
    logic [AW:0]   f_count;

    bram_fifo_ex #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .full(s_full), .almost_full(s_afull), .rd_en(rd_en), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .empty(s_empty), .almost_empty(s_aempty),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(s_ovf),
        .underflow(s_unf), .err_clr(err_clr), .data_count(s_count)
    );

    bram_fifo_ex #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_fw (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .full(f_full), .almost_full(f_afull), .rd_en(rd_en), .rd_data(f_rd_data),
        .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_aempty),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(f_ovf),
        .underflow(f_unf), .err_clr(err_clr), .data_count(f_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain word queues. FWFT words are stamped with their write edge
    // and become visible at the head two edges later.
    typedef struct {
        logic [DW-1:0] d;
        int            stamp;
    } fw_word_t;

    logic [DW-1:0] sq[$];
    logic [DW-1:0] exp_std[$];
    fw_word_t      fq[$];
    int            cyc = 0;
    bit            m_s_ovf, m_s_unf, m_s_rv, m_f_ovf, m_f_unf;
    bit            m_vis, m_sfull, m_sempty, m_ffull;

    function automatic bit fw_vis();
        return (fq.size() > 0) && (cyc >= fq[0].stamp + 2);
    endfunction

    always @(negedge rst_n) begin
        sq.delete();
        exp_std.delete();
        fq.delete();
        m_s_ovf = 0; m_s_unf = 0; m_s_rv = 0; m_f_ovf = 0; m_f_unf = 0;
    end

    always @(posedge clk) begin
        m_vis = fw_vis();
        cyc++;
        if (!rst_n) begin
            m_s_rv = 0;
        end else if (flush) begin
            sq.delete();
            fq.delete();
            m_s_ovf = 0; m_s_unf = 0; m_s_rv = 0; m_f_ovf = 0; m_f_unf = 0;
        end else begin
            m_sfull  = (sq.size() == DEPTH);
            m_sempty = (sq.size() == 0);
            m_s_rv   = rd_en && !m_sempty;
            if (m_s_rv) exp_std.push_back(sq.pop_front());
            if (wr_en && !m_sfull) sq.push_back(wr_data);
            m_s_ovf = (wr_en && m_sfull) || (m_s_ovf && !err_clr);
            m_s_unf = (rd_en && m_sempty) || (m_s_unf && !err_clr);

            m_ffull = (fq.size() == DEPTH);
            if (rd_en && m_vis) void'(fq.pop_front());
            if (wr_en && !m_ffull) fq.push_back('{wr_data, cyc});
            m_f_ovf = (wr_en && m_ffull) || (m_f_ovf && !err_clr);
            m_f_unf = (rd_en && !m_vis) || (m_f_unf && !err_clr);
        end
    end

    // Monitor: compares every output against the model away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("std_count", s_count, sq.size());
            chk("std_full", s_full, sq.size() == DEPTH);
            chk("std_empty", s_empty, sq.size() == 0);
            chk("std_almost_full", s_afull, sq.size() >= int'(af_thresh));
            chk("std_almost_empty", s_aempty, sq.size() <= int'(ae_thresh));
            chk("std_overflow", s_ovf, m_s_ovf);
            chk("std_underflow", s_unf, m_s_unf);
            chk("std_rd_valid", s_rd_valid, m_s_rv);
            if (s_rd_valid) begin
                if (exp_std.size() == 0) chk("std_spurious_valid", s_rd_valid, 0);
                else chk("std_rd_data", s_rd_data, exp_std.pop_front());
            end
            chk("fw_count", f_count, fq.size());
            chk("fw_full", f_full, fq.size() == DEPTH);
            chk("fw_empty", f_empty, !fw_vis());
            chk("fw_almost_full", f_afull, fq.size() >= int'(af_thresh));
            chk("fw_almost_empty", f_aempty, fq.size() <= int'(ae_thresh));
            chk("fw_overflow", f_ovf, m_f_ovf);
            chk("fw_underflow", f_unf, m_f_unf);
            chk("fw_rd_valid", f_rd_valid, fw_vis());
            if (f_rd_valid && fw_vis()) chk("fw_rd_data", f_rd_data, fq[0].d);
        end
    end

    task automatic drive(input bit w, input logic [DW-1:0] d, input bit r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_std_count"}, s_count, 0);
        chk({tag, "_std_empty"}, s_empty, 1);
        chk({tag, "_std_full"}, s_full, 0);
        chk({tag, "_std_aempty"}, s_aempty, 1);
        chk({tag, "_std_rd_data"}, s_rd_data, 0);
        chk({tag, "_std_rd_valid"}, s_rd_valid, 0);
        chk({tag, "_std_ovf"}, s_ovf, 0);
        chk({tag, "_std_unf"}, s_unf, 0);
        chk({tag, "_fw_count"}, f_count, 0);
        chk({tag, "_fw_empty"}, f_empty, 1);
        chk({tag, "_fw_rd_valid"}, f_rd_valid, 0);
        chk({tag, "_fw_rd_data"}, f_rd_data, 0);
        chk({tag, "_fw_ovf"}, f_ovf, 0);
    endtask

    initial begin
        int gaps;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        chk("reset_std_afull", s_afull, 0);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(i), 1'b0);
        chk("fill_std_full", s_full, 1);
        chk("fill_std_count", s_count, DEPTH);
        chk("fill_fw_full", f_full, 1);
        drive(1'b1, 8'hEE, 1'b0);
        chk("fill_std_overflow", s_ovf, 1);
        chk("fill_fw_overflow", f_ovf, 1);
        chk("fill_extra_dropped", s_count, DEPTH);

        drive(1'b1, 8'h77, 1'b1);
        chk("simul_full_std_count", s_count, DEPTH - 1);
        chk("simul_full_fw_count", f_count, DEPTH - 1);

        for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 8'h00, 1'b1);
        chk("drain_std_empty", s_empty, 1);
        chk("drain_fw_empty", f_empty, 1);
        drive(1'b0, 8'h00, 1'b1);
        chk("underflow_set", s_unf, 1);
        err_clr = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        err_clr = 1'b0;
        chk("underflow_clr", s_unf, 0);
        chk("overflow_clr", s_ovf, 0);

        drive(1'b1, 8'h3C, 1'b1);
        chk("simul_empty_std_count", s_count, 1);
        chk("simul_empty_fw_count", f_count, 1);
        flush = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        flush = 1'b0;

        drive(1'b1, 8'hA5, 1'b0);
        chk("fwft_lat_e0", f_rd_valid, 0);
        drive(1'b0, 8'h00, 1'b0);
        chk("fwft_lat_e1", f_rd_valid, 0);
        drive(1'b0, 8'h00, 1'b0);
        chk("fwft_lat_e2_valid", f_rd_valid, 1);
        chk("fwft_lat_e2_data", f_rd_data, 8'hA5);
        chk("fwft_lat_e2_count", f_count, 1);
        drive(1'b0, 8'h00, 1'b1);
        chk("fwft_pop_empty", f_empty, 1);

        gaps = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, DW'($urandom), 1'b1);
            if (i >= 3 && !f_rd_valid) gaps++;
        end
        chk("fwft_stream_gaps", gaps, 0);
        for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 8'h00, 1'b1);
        chk("preflush_count", s_count, 9);
        chk("preflush_ovf", s_ovf, 1);
        flush = 1'b1;
        drive(1'b1, 8'h55, 1'b0);
        flush = 1'b0;
        chk("flush_std_count", s_count, 0);
        chk("flush_std_empty", s_empty, 1);
        chk("flush_std_ovf", s_ovf, 0);
        chk("flush_fw_count", f_count, 0);
        chk("flush_fw_rd_valid", f_rd_valid, 0);

        for (int i = 0; i < 400; i++) begin
            if (i == 150) begin af_thresh = 5'd0; ae_thresh = 5'd16; end
            if (i == 250) begin
                af_thresh = 5'($urandom_range(1, 16));
                ae_thresh = 5'($urandom_range(0, 15));
            end
            err_clr = ($urandom_range(0, 15) == 0);
            flush   = ($urandom_range(0, 79) == 0);
            if (i < 200) drive(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 2) == 0));
            else drive(($urandom_range(0, 2) == 0), DW'($urandom), ($urandom_range(0, 3) != 0));
        end
        err_clr = 1'b0;
        flush = 1'b0;
        af_thresh = 5'd12;
        ae_thresh = 5'd3;

        for (int i = 0; i < 6; i++) drive(1'b1, DW'($urandom), (i > 2));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 reset_checks("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
